// File: rtl/rand_pkg.sv
// rand_pkg: shared LFSR constants, checker state encoding and the 8-bit step function.
package rand_pkg;
  localparam logic [7:0] TAP = 8'h70;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  // Galois step for x^8+x^6+x^5+x^4+1: rotate left, fold the old MSB into bits 4..6.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] r);
    return {r[6:0], r[7]} ^ (r[7] ? TAP : 8'h00);
  endfunction
endpackage

// File: rtl/rand_chk_if.sv
// rand_chk_if: word stream in, lock/error status out.
//   in_valid, rand_in, clr_err : driven by master
//   locked, err_pulse, err_cnt : driven by the checker (slave)
interface rand_chk_if #(parameter int ERR_W = 16);
  logic             in_valid;
  logic [7:0]       rand_in;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  modport master (output in_valid, rand_in, clr_err, input locked, err_pulse, err_cnt);
  modport slave (input in_valid, rand_in, clr_err, output locked, err_pulse, err_cnt);
endinterface

// File: rtl/lfsr8_step.sv
// lfsr8_step: combinational 8-bit LFSR step f.
//   r  : current word
//   nx : f(r)
module lfsr8_step (
  input  logic [7:0] r,
  output logic [7:0] nx
);
  assign nx = rand_pkg::lfsr8_step(r);
endmodule

// File: rtl/rand_chk.sv
// rand_chk: self-synchronising checker for the 8-bit LFSR word stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rand_chk_if slave (in_valid, rand_in, clr_err -> locked, err_pulse, err_cnt)
//   RAND_CHK_BITERR_EN defined: err_cnt counts bit errors instead of word errors.
module rand_chk
  import rand_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input logic        clk,
  input logic        rst,
  rand_chk_if.slave  bus
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  state_t st, st_nx;
  logic [7:0] pred, pred_nx, f_in, f_pred;
  logic [MW-1:0] match, match_nx;
  logic [LW-1:0] miss, miss_nx;
  logic hit_err;
  logic [3:0] inc;
  logic [ERR_W:0] sum;
  logic [ERR_W-1:0] cnt_nx;
  lfsr8_step u_step_in (.r(bus.rand_in), .nx(f_in));
  lfsr8_step u_step_pred (.r(pred), .nx(f_pred));
  always_comb begin
    st_nx = st;
    pred_nx = pred;
    match_nx = match;
    miss_nx = miss;
    hit_err = 1'b0;
    if (bus.in_valid)
      case (st)
        HUNT:
          if (bus.rand_in != 8'h00) begin
            st_nx = VERIFY;
            pred_nx = f_in;
            match_nx = '0;
          end
        VERIFY:
          if (bus.rand_in == 8'h00)
            st_nx = HUNT;
          else if (bus.rand_in == pred) begin
            match_nx = match + 1'b1;
            pred_nx = f_in;
            if (match_nx == MW'(LOCK_CNT)) begin
              st_nx = LOCKED;
              miss_nx = '0;
            end
          end else begin
            pred_nx = f_in;
            match_nx = '0;
          end
        LOCKED: begin
          // Flywheel: the prediction only ever advances from itself once locked.
          pred_nx = f_pred;
          if (bus.rand_in == pred)
            miss_nx = '0;
          else begin
            hit_err = 1'b1;
            miss_nx = miss + 1'b1;
            if (miss_nx == LW'(LOSS_CNT))
              st_nx = HUNT;
          end
        end
        default: st_nx = HUNT;
      endcase
  end
`ifdef RAND_CHK_BITERR_EN
  assign inc = hit_err ? 4'($countones(bus.rand_in ^ pred)) : 4'd0;
`else
  assign inc = {3'b000, hit_err};
`endif
  // A clear that coincides with an error keeps just that error's increment.
  assign sum = {1'b0, bus.clr_err ? {ERR_W{1'b0}} : bus.err_cnt} + (ERR_W+1)'(inc);
  assign cnt_nx = sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= HUNT;
      pred <= 8'h00;
      match <= '0;
      miss <= '0;
      bus.locked <= 1'b0;
      bus.err_pulse <= 1'b0;
      bus.err_cnt <= '0;
    end else begin
      st <= st_nx;
      pred <= pred_nx;
      match <= match_nx;
      miss <= miss_nx;
      bus.locked <= st_nx == LOCKED;
      bus.err_pulse <= hit_err;
      bus.err_cnt <= cnt_nx;
    end
endmodule
